if_fetch_unit: RTL and testbench

//  IF-stage producer for the IF/ID pipeline register: holds the PC and fetches one instruction at a time

---
 rtl/if_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// IF-stage fetch unit: owns the PC, fetches one instruction at a time from
// instruction memory over a req/ready handshake, and presents the held
// instruction to the IF/ID register. Handles branch/jump redirects and a
// fetch timeout that vectors to EXC_PC.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC      = 32'h80000000,
    parameter logic [31:0] EXC_PC        = 32'h80000004,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IF_ID_Write,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] oNextPC,
    output logic [31:0] oInstruction,
    output logic        oValid,
    output logic        fetch_err
);

    localparam int CNT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(FETCH_TIMEOUT - 1);
    localparam logic [31:0] NEXTPC_RST = 32'h80000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t           state;
    logic [31:0]      pc;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;
    logic [31:0]      drain_pc;

    // PC + 4 that keeps the kernel bit (bit 31) and wraps the low 31 bits.
    function automatic logic [31:0] inc_pc(input logic [31:0] x);
        return {x[31], x[30:0] + 31'd4};
    endfunction

    assign timeout_hit = (wait_cnt == TMO_LAST);
    // A redirect arriving while draining still wins over the pc it redirected to.
    assign drain_pc    = redirect_valid ? redirect_pc : pc;

    // Fetch FSM with all outputs registered; imem_addr follows pc except in
    // DRAIN, where the outstanding request's address must stay on the bus.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            wait_cnt     <= '0;
            imem_req     <= 1'b0;
            imem_addr    <= RESET_PC;
            oValid       <= 1'b0;
            oInstruction <= 32'h0;
            oNextPC      <= NEXTPC_RST;
            fetch_err    <= 1'b0;
        end else begin
            fetch_err <= 1'b0;
            case (state)
                IDLE: begin
                    state     <= FETCH;
                    pc        <= drain_pc;
                    imem_req  <= 1'b1;
                    imem_addr <= drain_pc;
                    wait_cnt  <= '0;
                end
                FETCH: begin
                    if (redirect_valid && imem_ready) begin
                        // Returned word belongs to the old path: drop it and
                        // restart immediately at the target.
                        pc        <= redirect_pc;
                        imem_addr <= redirect_pc;
                        wait_cnt  <= '0;
                    end else if (redirect_valid) begin
                        // Memory still owes us the old word; wait it out with
                        // the old address held.
                        pc       <= redirect_pc;
                        state    <= DRAIN;
                        wait_cnt <= '0;
                    end else if (imem_ready) begin
                        oValid       <= 1'b1;
                        oInstruction <= imem_rdata;
                        oNextPC      <= inc_pc(pc);
                        pc           <= inc_pc(pc);
                        imem_addr    <= inc_pc(pc);
                        imem_req     <= 1'b0;
                        state        <= HOLD;
                    end else if (timeout_hit) begin
                        fetch_err <= 1'b1;
                        pc        <= EXC_PC;
                        imem_addr <= EXC_PC;
                        imem_req  <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    pc <= drain_pc;
                    if (imem_ready || timeout_hit) begin
                        // Stale data or an abandoned request: discard silently.
                        imem_addr <= drain_pc;
                        state     <= FETCH;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        pc           <= redirect_pc;
                        imem_addr    <= redirect_pc;
                        imem_req     <= 1'b1;
                        oValid       <= 1'b0;
                        oInstruction <= 32'h0;
                        state        <= FETCH;
                        wait_cnt     <= '0;
                    end else if (IF_ID_Write) begin
                        imem_addr    <= pc;
                        imem_req     <= 1'b1;
                        oValid       <= 1'b0;
                        oInstruction <= 32'h0;
                        state        <= FETCH;
                        wait_cnt     <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed testbench for if_fetch_unit with an expected-output scoreboard.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        IF_ID_Write;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] oNextPC;
    logic [31:0] oInstruction;
    logic        oValid;
    logic        fetch_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] sb_q[$];
    logic bad_seen = 1'b0;
    logic early_err;

    if_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .IF_ID_Write    (IF_ID_Write),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .oNextPC        (oNextPC),
        .oInstruction   (oInstruction),
        .oValid         (oValid),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    // Any appearance of a discarded (old-path) word as a valid instruction.
    always @(negedge clk) begin
        if (oValid === 1'b1 && oInstruction === 32'hDEADBEEF) bad_seen = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic [31:0] instr, input logic [31:0] npc);
        sb_q.push_back({instr, npc});
    endtask

    task automatic sb_check(input string tag);
        logic [63:0] e;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_valid"}, 32'(oValid), 32'd1);
            chk({tag, "_instr"}, oInstruction, e[63:32]);
            chk({tag, "_npc"}, oNextPC, e[31:0]);
        end
    endtask

    initial begin
        reset = 1'b0; IF_ID_Write = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; imem_ready = 1'b0; imem_rdata = 32'h0;

        // 1. Reset held three cycles, then release
        repeat (3) step();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h80000000);
        chk("rst_valid", 32'(oValid), 32'd0);
        chk("rst_instr", oInstruction, 32'h0);
        chk("rst_npc", oNextPC, 32'h80000000);
        chk("rst_err", 32'(fetch_err), 32'd0);
        reset = 1'b1;
        step();
        chk("t1_req", 32'(imem_req), 32'd1);
        chk("t1_addr", imem_addr, 32'h80000000);
        chk("t1_valid", 32'(oValid), 32'd0);
        chk("t1_npc", oNextPC, 32'h80000000);

        // 2. Ready two cycles after request, consume immediately
        step();
        IF_ID_Write = 1'b1;
        imem_ready = 1'b1; imem_rdata = 32'h2402000A;
        sb_push(32'h2402000A, 32'h80000004);
        step();
        imem_ready = 1'b0;
        sb_check("t2_out");
        chk("t2_req_low", 32'(imem_req), 32'd0);
        step();
        chk("t2_req", 32'(imem_req), 32'd1);
        chk("t2_addr", imem_addr, 32'h80000004);
        chk("t2_valid_low", 32'(oValid), 32'd0);
        chk("t2_instr_nop", oInstruction, 32'h0);
        chk("t2_npc_keep", oNextPC, 32'h80000004);

        // 3. Stall in HOLD for four cycles, then consume
        IF_ID_Write = 1'b0;
        imem_ready = 1'b1; imem_rdata = 32'h00000013;
        sb_push(32'h00000013, 32'h80000008);
        step();
        imem_ready = 1'b0;
        sb_check("t3_out");
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_stall_valid", 32'(oValid), 32'd1);
            chk("t3_stall_instr", oInstruction, 32'h00000013);
            chk("t3_stall_npc", oNextPC, 32'h80000008);
            chk("t3_stall_req", 32'(imem_req), 32'd0);
        end
        IF_ID_Write = 1'b1;
        step();
        IF_ID_Write = 1'b0;
        chk("t3_req", 32'(imem_req), 32'd1);
        chk("t3_addr", imem_addr, 32'h80000008);
        chk("t3_valid_low", 32'(oValid), 32'd0);

        // 4. Redirect while the fetch is pending: drain the stale word
        redirect_valid = 1'b1; redirect_pc = 32'h80000100;
        step();
        redirect_valid = 1'b0;
        chk("t4_drain_req", 32'(imem_req), 32'd1);
        chk("t4_drain_addr", imem_addr, 32'h80000008);
        step();
        chk("t4_drain_addr2", imem_addr, 32'h80000008);
        imem_ready = 1'b1; imem_rdata = 32'hDEADBEEF;
        step();
        imem_ready = 1'b0;
        chk("t4_new_req", 32'(imem_req), 32'd1);
        chk("t4_new_addr", imem_addr, 32'h80000100);
        chk("t4_valid_low", 32'(oValid), 32'd0);
        imem_ready = 1'b1; imem_rdata = 32'h11111111;
        sb_push(32'h11111111, 32'h80000104);
        step();
        imem_ready = 1'b0;
        sb_check("t4_out");
        IF_ID_Write = 1'b1;
        step();
        IF_ID_Write = 1'b0;
        chk("t4_next_addr", imem_addr, 32'h80000104);

        // 5. Memory never answers: timeout after 16 cycles
        early_err = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            early_err = early_err | fetch_err;
        end
        chk("t5_no_early_err", 32'(early_err), 32'd0);
        chk("t5_req_still", 32'(imem_req), 32'd1);
        step();
        chk("t5_err_pulse", 32'(fetch_err), 32'd1);
        chk("t5_req_drop", 32'(imem_req), 32'd0);
        step();
        chk("t5_err_clear", 32'(fetch_err), 32'd0);
        chk("t5_exc_req", 32'(imem_req), 32'd1);
        chk("t5_exc_addr", imem_addr, 32'h80000004);

        // 6. Kernel-bit increment rule, reached via redirect+ready and via drain
        redirect_valid = 1'b1; redirect_pc = 32'h7FFFFFFC;
        imem_ready = 1'b1; imem_rdata = 32'hCAFEBABE;
        step();
        redirect_valid = 1'b0; imem_ready = 1'b0;
        chk("t6_drop_req", 32'(imem_req), 32'd1);
        chk("t6_drop_addr", imem_addr, 32'h7FFFFFFC);
        chk("t6_drop_valid", 32'(oValid), 32'd0);
        imem_ready = 1'b1; imem_rdata = 32'hAAAA0001;
        sb_push(32'hAAAA0001, 32'h00000000);
        step();
        imem_ready = 1'b0;
        sb_check("t6_wrap_low");
        IF_ID_Write = 1'b1;
        step();
        IF_ID_Write = 1'b0;
        chk("t6_addr_zero", imem_addr, 32'h00000000);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFC;
        step();
        redirect_valid = 1'b0;
        chk("t6_drain_addr", imem_addr, 32'h00000000);
        imem_ready = 1'b1; imem_rdata = 32'hDEADBEEF;
        step();
        imem_ready = 1'b0;
        chk("t6_hi_addr", imem_addr, 32'hFFFFFFFC);
        imem_ready = 1'b1; imem_rdata = 32'hBBBB0002;
        sb_push(32'hBBBB0002, 32'h80000000);
        step();
        imem_ready = 1'b0;
        sb_check("t6_wrap_high");

        // 7. Redirect and consume together in HOLD: redirect wins
        redirect_valid = 1'b1; redirect_pc = 32'h80000200; IF_ID_Write = 1'b1;
        step();
        redirect_valid = 1'b0; IF_ID_Write = 1'b0;
        chk("t7_valid_low", 32'(oValid), 32'd0);
        chk("t7_instr_nop", oInstruction, 32'h0);
        chk("t7_npc_keep", oNextPC, 32'h80000000);
        chk("t7_addr", imem_addr, 32'h80000200);

        // Reset in the middle of a handshake
        reset = 1'b0;
        step();
        chk("rst2_req", 32'(imem_req), 32'd0);
        chk("rst2_addr", imem_addr, 32'h80000000);
        reset = 1'b1;
        step();
        chk("rst2_restart", 32'(imem_req), 32'd1);

        chk("stale_never_valid", 32'(bad_seen), 32'd0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
